// File: rtl/duck_frame_tx.sv
// duck_frame_tx: snapshots the upstream hash on each sync_lock rise and streams [SYNC_BYTE, payload MSB-first, XOR checksum]
//   clk, rst         clock, synchronous active-high reset
//   hash_in          upstream hash, captured on a sync_lock rising edge while idle
//   sync_lock        upstream lock flag; rising edge requests a frame
//   out_data/valid/last/ready  valid/ready byte stream; out_last marks the checksum byte
//   busy             frame in flight
//   drop_cnt         saturating count of requests lost while busy
module duck_frame_tx #(
    parameter int         HASH_W    = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hD5,
    parameter int         DROP_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [HASH_W-1:0] hash_in,
    input  logic              sync_lock,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);
    localparam int NB = HASH_W / 8;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    typedef enum logic [1:0] {IDLE, HDR, PAY, CSUM} state_t;
    state_t            state, state_n;
    logic              sync_q, rise, acc;
    logic [HASH_W-1:0] shreg;
    logic [7:0]        csum;
    logic [IW-1:0]     idx;
    assign rise = sync_lock & ~sync_q;
    // Outputs depend only on state, so acceptance never feeds back into out_valid.
    assign acc  = (state != IDLE) & out_ready;
    always_comb begin
        state_n   = state;
        out_valid = state != IDLE;
        busy      = state != IDLE;
        out_last  = state == CSUM;
        out_data  = state == HDR  ? SYNC_BYTE :
                    state == PAY  ? shreg[HASH_W-1 -: 8] :
                    state == CSUM ? csum : 8'h00;
        case (state)
            IDLE:    if (rise) state_n = HDR;
            HDR:     if (acc) state_n = PAY;
            PAY:     if (acc && idx == IW'(NB - 1)) state_n = CSUM;
            CSUM:    if (acc) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sync_q   <= 1'b0;
            shreg    <= '0;
            csum     <= 8'h00;
            idx      <= '0;
            drop_cnt <= '0;
        end else begin
            state  <= state_n;
            sync_q <= sync_lock;
            if (state == IDLE && rise) begin
                shreg <= hash_in;
                csum  <= 8'h00;
                idx   <= '0;
            end
            if (state == PAY && acc) begin
                shreg <= shreg << 8;
                csum  <= csum ^ shreg[HASH_W-1 -: 8];
                idx   <= idx + 1'b1;
            end
            // A rise outside IDLE is lost, including one on the final accept cycle.
            if (rise && state != IDLE && ~&drop_cnt) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule
